pipe_prefetch: RTL and testbench

PIPE_PREFETCH -- requirements
Module: pipe_prefetch

---
 rtl/zip_pf_pkg.sv | 19 +
 rtl/pf_fifo.sv | 47 ++++
 rtl/pipe_prefetch.sv | 188 ++++++++++++++++++
 tb/tb_pipe_prefetch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/zip_pf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zip_pf_pkg
// Brief    : Prefetch FSM state encoding and fixed Wishbone read-master values.
// Revision : 1.0
// ============================================================================
package zip_pf_pkg;

   typedef enum logic [1:0] {
      PF_IDLE = 2'd0,
      PF_BUS  = 2'd1,
      PF_HALT = 2'd2
   } pf_state_t;

   localparam logic        c_wb_we   = 1'b0;
   localparam logic [31:0] c_wb_data = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pf_fifo
// Brief    : Instruction buffer, 2^LGFIFO x WIDTH, show-ahead head, sync flush.
// Revision : 1.0
// ============================================================================
module pf_fifo #(
   parameter int LGFIFO = 3,
   parameter int WIDTH  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic              pop_i,
   output logic [WIDTH-1:0]  data_o,
   output logic              empty_o,
   output logic [LGFIFO:0]   fill_o
);
   localparam int DEPTH = 1 << LGFIFO;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [LGFIFO:0]  wr_q;
   logic [LGFIFO:0]  rd_q;

   // Pointers carry one extra bit so full and empty are distinguishable.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q[LGFIFO-1:0]] <= data_i;
   end

   assign data_o  = mem_q[rd_q[LGFIFO-1:0]];
   assign fill_o  = wr_q - rd_q;
   assign empty_o = (wr_q == rd_q);

endmodule
`default_nettype wire

// File: rtl/pipe_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : pipe_prefetch
// Brief    : Pipelined Wishbone instruction prefetch with credit-limited issue.
//            Define PIPE_PREFETCH_BUSERR_EN to halt on bus error with a marker.
// Revision : 1.0
// ============================================================================
module pipe_prefetch
   import zip_pf_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 30,
   parameter int LGFIFO        = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_new_pc,
   input  logic                     i_clear_cache,
   input  logic                     i_stalled_n,
   input  logic [ADDRESS_WIDTH-1:0] i_pc,
   output logic [31:0]              o_i,
   output logic [ADDRESS_WIDTH-1:0] o_pc,
   output logic                     o_valid,
   output logic                     o_illegal,
   output logic                     o_wb_cyc,
   output logic                     o_wb_stb,
   output logic                     o_wb_we,
   output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
   output logic [31:0]              o_wb_data,
   input  logic                     i_wb_ack,
   input  logic                     i_wb_stall,
   input  logic                     i_wb_err,
   input  logic [31:0]              i_wb_data
);
   localparam int AW = ADDRESS_WIDTH;
   localparam int OW = LGFIFO + 1;
   localparam int CW = LGFIFO + 2;
   localparam logic [CW-1:0] c_depth = CW'(1 << LGFIFO);

   pf_state_t     state_q, state_d;
   logic          cyc_q, cyc_d;
   logic          stb_q, stb_d;
   logic          started_q, started_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [OW-1:0] outst_q, outst_d;

   logic          w_redirect, w_issue, w_ack, w_err, w_pop, w_empty, w_room;
   logic [OW-1:0] w_fill, w_outst_nx;
   logic [CW-1:0] w_fill_nx;
   logic [31:0]   w_head;

   assign w_redirect = i_new_pc | i_clear_cache;
   assign w_issue    = stb_q & ~i_wb_stall;
   assign w_err      = cyc_q & i_wb_err & ~w_redirect;
   assign w_ack      = cyc_q & i_wb_ack & ~i_wb_err & ~w_redirect;
   assign w_pop      = ~w_empty & i_stalled_n;
   assign w_outst_nx = outst_q + OW'(w_issue) - OW'(w_ack);
   assign w_fill_nx  = CW'(w_fill) + CW'(w_ack) - CW'(w_pop);
   // Room for one more request once this cycle's issue/ack/pop have landed.
   assign w_room     = (w_fill_nx + CW'(w_outst_nx)) < c_depth;

   pf_fifo #(
      .LGFIFO (LGFIFO),
      .WIDTH  (32)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .flush_i (w_redirect),
      .push_i  (w_ack),
      .data_i  (i_wb_data),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .empty_o (w_empty),
      .fill_o  (w_fill)
   );

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      started_d = started_q;
      outst_d   = w_outst_nx;
      addr_d    = addr_q + AW'(w_issue);
      pc_d      = pc_q + AW'(w_pop);

      case (state_q)
         PF_IDLE: begin
            if (started_q && w_room) begin
               state_d = PF_BUS;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
            end
         end
         PF_BUS: begin
            if (w_err) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               outst_d = '0;
`ifdef PIPE_PREFETCH_BUSERR_EN
               state_d = PF_HALT;
`else
               // Oldest unanswered request is the one that faulted.
               state_d = PF_IDLE;
               addr_d  = addr_q - AW'(outst_q);
`endif
            end else begin
               stb_d = w_room;
               if (!w_room && (w_outst_nx == '0)) begin
                  state_d = PF_IDLE;
                  cyc_d   = 1'b0;
               end
            end
         end
         PF_HALT: begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
         end
         default: begin
            state_d = PF_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
         end
      endcase

      // An active cycle must be dropped for a cycle before refetching.
      if (w_redirect) begin
         state_d   = cyc_q ? PF_IDLE : PF_BUS;
         cyc_d     = ~cyc_q;
         stb_d     = ~cyc_q;
         outst_d   = '0;
         started_d = 1'b1;
         addr_d    = i_pc;
         pc_d      = i_pc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= PF_IDLE;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         outst_q   <= '0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         outst_q   <= outst_d;
         started_q <= started_d;
      end
   end

   always_ff @(posedge i_clk) begin
      addr_q <= addr_d;
      pc_q   <= pc_d;
   end

`ifdef PIPE_PREFETCH_BUSERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((state_q == PF_BUS) && w_err) err_d = 1'b1;
      if (w_redirect)                    err_d = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   // The marker sits behind every word buffered before the fault.
   assign o_illegal = err_q & w_empty;
`else
   assign o_illegal = 1'b0;
`endif

   assign o_i       = w_head;
   assign o_pc      = pc_q;
   assign o_valid   = ~w_empty;
   assign o_wb_cyc  = cyc_q;
   assign o_wb_stb  = stb_q;
   assign o_wb_we   = c_wb_we;
   assign o_wb_addr = addr_q;
   assign o_wb_data = c_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_pipe_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_prefetch
// Brief    : Randomised Wishbone slave plus instruction-stream scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pipe_prefetch;
   localparam int AW    = 30;
   localparam int LGF   = 3;
   localparam int DEPTH = 1 << LGF;

   logic          clk = 1'b0;
   logic          rst, new_pc, clear_cache, stalled_n;
   logic [AW-1:0] pc;
   logic [31:0]   o_i;
   logic [AW-1:0] o_pc, o_wb_addr;
   logic          o_valid, o_illegal, o_wb_cyc, o_wb_stb, o_wb_we;
   logic [31:0]   o_wb_data;
   logic          i_wb_ack, i_wb_stall, i_wb_err;
   logic [31:0]   i_wb_data;

   always #5 clk = ~clk;

   pipe_prefetch #(.ADDRESS_WIDTH(AW), .LGFIFO(LGF)) dut (
      .i_clk(clk), .i_rst(rst), .i_new_pc(new_pc), .i_clear_cache(clear_cache),
      .i_stalled_n(stalled_n), .i_pc(pc), .o_i(o_i), .o_pc(o_pc), .o_valid(o_valid),
      .o_illegal(o_illegal), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .i_wb_ack(i_wb_ack),
      .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
   );

   int checks = 0, failures = 0;
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] pend_q[$];
   logic [AW-1:0] exp_next = '0, exp_req = '0, redir_pc = '0;
   int  buf_cnt = 0, good_reqs = 0, pops = 0, acks_since = 0;
   int  stall_pct = 0, ready_pct = 100, slow_pct = 0, err_pct = 0, err_on_n = 0;
   bit  do_redir = 0, do_rst = 0, force_ack = 0, armed = 0, saw_zero = 0;
   bit  prev_ack = 0, prev_pop = 0, prev_flush = 0;

   function automatic logic [31:0] mem(input logic [AW-1:0] a);
      return {2'b00, a} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // One bus cycle: drive slave/consumer before the edge, return just after it.
   task automatic tick();
      logic [AW-1:0] a;
      bit abort, err_now;
      @(negedge clk);
      if (prev_flush) buf_cnt = 0;
      else            buf_cnt = buf_cnt + int'(prev_ack) - int'(prev_pop);
      if (!o_wb_cyc) pend_q.delete();
      if (armed) begin
         check("valid_model", 64'(o_valid), 64'(buf_cnt > 0));
         check("credit", 64'(buf_cnt + pend_q.size() <= DEPTH), 64'(1));
`ifndef PIPE_PREFETCH_BUSERR_EN
         check("illegal_off", 64'(o_illegal), 64'(0));
`endif
      end
      abort   = do_rst || do_redir;
      err_now = 0;
      i_wb_ack = 0; i_wb_err = 0; new_pc = 0; clear_cache = 0; rst = 0;
      prev_ack = 0; prev_flush = abort;
      if (force_ack) begin
         i_wb_ack = 1; i_wb_data = 32'hDEAD_BEEF; force_ack = 0;
      end else if (o_wb_cyc && pend_q.size() > 0 && $urandom_range(99) >= slow_pct) begin
         a = pend_q.pop_front();
         acks_since++;
         if (!abort && ((err_on_n != 0 && acks_since == err_on_n) || $urandom_range(99) < err_pct)) begin
            i_wb_err = 1; err_now = 1; exp_req = a;
         end else begin
            i_wb_ack = 1; i_wb_data = mem(a); prev_ack = !abort;
         end
      end
      i_wb_stall = ($urandom_range(99) < stall_pct);
      stalled_n  = !abort && ($urandom_range(99) < ready_pct);
      prev_pop   = o_valid && stalled_n;
      if (o_wb_stb && !i_wb_stall) begin
         pend_q.push_back(o_wb_addr);
         if (armed && !abort && !err_now) begin
            check("req_addr", 64'(o_wb_addr), 64'(exp_req));
            exp_req++;
            good_reqs++;
         end
      end
      if (do_redir) begin
         if ($urandom_range(1) != 0) new_pc = 1; else clear_cache = 1;
         pc = redir_pc;
         exp_q.delete();
         exp_next = redir_pc; exp_req = redir_pc; acks_since = 0; do_redir = 0;
      end
      if (do_rst) begin
         rst = 1; exp_q.delete(); do_rst = 0;
      end
      while (exp_q.size() < 32) begin
         exp_q.push_back(exp_next);
         exp_next++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      logic [AW-1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (o_valid && stalled_n && !rst) begin
            pops++;
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL sb_empty actual=pc %0h required=no output", o_pc);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", 64'(o_pc), 64'(e));
               check("sb_data", 64'(o_i), 64'(mem(e)));
               if (o_pc == '0) saw_zero = 1;
            end
         end
      end
   end

   initial begin : stim
      int p0, g0, n;
      rst = 1; new_pc = 0; clear_cache = 0; stalled_n = 0; pc = '0;
      i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0; i_wb_data = '0;

      do_rst = 1; tick(); armed = 1; tick();
      check("rst_cyc", 64'(o_wb_cyc), 64'(0));
      check("rst_stb", 64'(o_wb_stb), 64'(0));
      check("rst_valid", 64'(o_valid), 64'(0));
      check("rst_illegal", 64'(o_illegal), 64'(0));
      check("wb_we", 64'(o_wb_we), 64'(0));
      check("wb_wdata", 64'(o_wb_data), 64'(0));

      // Zero-wait slave, consumer always ready: one instruction per cycle.
      redir_pc = AW'(32'h100); do_redir = 1; p0 = pops; tick();
      check("idle_redir_cyc", 64'(o_wb_cyc & o_wb_stb), 64'(1));
      check("idle_redir_addr", 64'(o_wb_addr), 64'(32'h100));
      repeat (19) tick();
      check("stream_rate", 64'(pops - p0), 64'(17));

      // Stalled consumer fills exactly the credit window.
      ready_pct = 0; redir_pc = AW'(32'h100); do_redir = 1; tick();
      g0 = good_reqs;
      repeat (30) tick();
      check("credit_reqs", 64'(good_reqs - g0), 64'(DEPTH));
      check("credit_stb", 64'(o_wb_stb), 64'(0));
      check("credit_valid", 64'(o_valid), 64'(1));
      check("credit_pc", 64'(o_pc), 64'(32'h100));
      check("credit_head", 64'(o_i), 64'(mem(AW'(32'h100))));
      ready_pct = 100; repeat (20) tick();

      // Redirect with three requests outstanding; ack in redirect cycle is stale.
      ready_pct = 0; slow_pct = 100; redir_pc = AW'(32'h180); do_redir = 1; tick();
      n = 0;
      while (pend_q.size() < 3 && n < 20) begin tick(); n++; end
      check("outst_three", 64'(pend_q.size()), 64'(3));
      slow_pct = 0; redir_pc = AW'(32'h200); do_redir = 1; tick();
      check("bus_redir_abort", 64'(o_wb_cyc), 64'(0));
      tick();
      check("bus_redir_cyc", 64'(o_wb_cyc & o_wb_stb), 64'(1));
      check("bus_redir_addr", 64'(o_wb_addr), 64'(32'h200));
      ready_pct = 100; n = 0;
      while (!o_valid && n < 20) begin tick(); n++; end
      check("first_after_redir", 64'(o_pc), 64'(32'h200));
      repeat (10) tick();

      // Reset while a bus cycle is active.
      slow_pct = 50; ready_pct = 50; redir_pc = AW'(32'h400); do_redir = 1; tick();
      repeat (3) tick();
      check("pre_rst_cyc", 64'(o_wb_cyc), 64'(1));
      do_rst = 1; tick();
      check("rst_mid_cyc", 64'(o_wb_cyc), 64'(0));
      check("rst_mid_valid", 64'(o_valid), 64'(0));
      force_ack = 1; tick();
      check("late_ack_valid", 64'(o_valid), 64'(0));

      // Address wrap at the top of the space under a toggling stall.
      slow_pct = 0; stall_pct = 50; ready_pct = 100; saw_zero = 0;
      redir_pc = ~AW'(2); do_redir = 1; tick();
      repeat (40) tick();
      check("wrap_seen", 64'(saw_zero), 64'(1));

`ifdef PIPE_PREFETCH_BUSERR_EN
      // Error on the third word: two words, then a held marker, no more requests.
      stall_pct = 0; ready_pct = 0; err_on_n = 3; redir_pc = AW'(32'h300); do_redir = 1; tick();
      repeat (10) tick();
      check("err_valid", 64'(o_valid), 64'(1));
      check("err_pc", 64'(o_pc), 64'(32'h300));
      check("err_cyc", 64'(o_wb_cyc), 64'(0));
      ready_pct = 100; g0 = good_reqs; repeat (10) tick();
      check("err_marker_valid", 64'(o_valid), 64'(0));
      check("err_marker_illegal", 64'(o_illegal), 64'(1));
      check("err_no_reqs", 64'(good_reqs - g0), 64'(0));
      err_on_n = 0; redir_pc = AW'(32'h500); do_redir = 1; tick();
      check("err_cleared", 64'(o_illegal), 64'(0));
`else
      // Error on the third word refetches from the failing address.
      stall_pct = 0; ready_pct = 60; err_on_n = 3; redir_pc = AW'(32'h300); do_redir = 1; tick();
      p0 = pops; repeat (30) tick();
      check("err_retry_progress", 64'(pops - p0 > 10), 64'(1));
      err_on_n = 0; err_pct = 5;
`endif

      // Randomised traffic with occasional redirects.
      stall_pct = 30; ready_pct = 70; slow_pct = 30;
      repeat (1500) begin
         if ($urandom_range(99) < 3) begin
            if ($urandom_range(3) == 0) redir_pc = ~AW'($urandom_range(5));
            else                        redir_pc = AW'($urandom);
            do_redir = 1;
         end
         tick();
      end
      err_pct = 0; stall_pct = 0; slow_pct = 0; ready_pct = 100;
      repeat (20) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
